// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module : ram_arb_pkg
// Brief  : Shared types and defaults for the two-port RAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 33;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
// ============================================================================
// Module : rr_arbiter_2
// Brief  : Combinational two-way round-robin pick; favours the port not served last.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter_2
    import ram_arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    output logic grant_b,
    output logic grant_valid
);

    assign grant_valid = req_a | req_b;
    assign grant_b     = req_b & (~req_a | (last == PORT_A));

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module : ram_port_arbiter
// Brief  : Shares one single-port RAM between two requesters, one 3-cycle access per grant.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_err,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_err,
    output logic              busy,
    output logic              MemWrite,
    output logic              MemRead,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WriteData,
    input  logic [DATA_W-1:0] MemData_in
);

    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_W-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                w_grant_b, w_grant_valid, w_out_of_range;
    logic                w_mem_write, w_mem_read;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_wdata;

    rr_arbiter_2 u_arb (
        .req_a       (a_req),
        .req_b       (b_req),
        .last        (last_q),
        .grant_b     (w_grant_b),
        .grant_valid (w_grant_valid)
    );

    assign w_out_of_range = (addr_q > C_LAST_ADDR);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        a_err_d     = 1'b0;
        b_err_d     = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        w_mem_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (w_grant_valid) begin
                    owner_d = w_grant_b;
                    last_d  = w_grant_b;
                    if (w_grant_b == PORT_B) begin
                        we_d    = b_we;
                        addr_d  = b_addr;
                        wdata_d = b_wdata;
                    end else begin
                        we_d    = a_we;
                        addr_d  = a_addr;
                        wdata_d = a_wdata;
                    end
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                w_mem_addr  = addr_q;
                w_mem_wdata = wdata_q;
                if (!w_out_of_range) begin
                    w_mem_write = we_q;
                    w_mem_read  = ~we_q;
                end
                // Ack/err are registered here so they appear exactly in DONE.
                if (owner_q == PORT_A) begin
                    a_ack_d = 1'b1;
                    a_err_d = w_out_of_range;
                    if (!we_q && !w_out_of_range) a_rdata_d = MemData_in;
                end else begin
                    b_ack_d = 1'b1;
                    b_err_d = w_out_of_range;
                    if (!we_q && !w_out_of_range) b_rdata_d = MemData_in;
                end
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= PORT_A;
            last_q    <= PORT_B;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // Strobes are gated by reset directly so an access aborted mid-cycle never touches the RAM.
    assign MemWrite  = w_mem_write & reset;
    assign MemRead   = w_mem_read & reset;
    assign Address   = w_mem_addr;
    assign WriteData = w_mem_wdata;
    assign busy      = (state_q != IDLE);
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_err     = a_err_q;
    assign b_err     = b_err_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module : tb_ram_port_arbiter
// Brief  : Self-checking bench for ram_port_arbiter with a behavioural RAM and reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 33;

    logic              clk, reset;
    logic              a_req, a_we, a_ack, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata, a_rdata;
    logic              b_req, b_we, b_ack, b_err;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata, b_rdata;
    logic              busy, MemWrite, MemRead;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData, MemData_in;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] ram     [0:255];
    logic [DATA_W-1:0] ref_mem [0:255];
    logic [DATA_W-1:0] exp_rd  [0:1];
    logic              ram_clear;
    int                bad_strobes;

    ram_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .busy(busy), .MemWrite(MemWrite), .MemRead(MemRead),
        .Address(Address), .WriteData(WriteData), .MemData_in(MemData_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM plus a counter of strobes issued to out-of-range addresses.
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= '0;
            bad_strobes <= 0;
        end else begin
            if (MemWrite) ram[Address] <= WriteData;
            if ((MemWrite || MemRead) && (Address > 8'(DEPTH - 1))) bad_strobes <= bad_strobes + 1;
        end
    end
    assign MemData_in = ram[Address];

    task automatic drive_port(input bit p, input bit req, input bit we,
                              input logic [7:0] addr, input logic [7:0] wd);
        if (!p) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wd; end
        else    begin b_req = req; b_we = we; b_addr = addr; b_wdata = wd; end
    endtask

    // Expected outcome of one completed access, applied in completion order.
    task automatic model_apply(input bit p, input bit we, input logic [7:0] addr,
                               input logic [7:0] wd, output logic e_err, output logic [7:0] e_rd);
        e_err = (int'(addr) >= DEPTH);
        if (!e_err) begin
            if (we) ref_mem[addr] = wd;
            else    exp_rd[p]     = ref_mem[addr];
        end
        e_rd = exp_rd[p];
    endtask

    task automatic run_txn(input bit p, input bit we, input logic [7:0] addr, input logic [7:0] wd,
                           output int lat, output logic err, output logic [7:0] rd);
        @(negedge clk);
        drive_port(p, 1'b1, we, addr, wd);
        lat = -1; err = 1'b0; rd = '0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if ((p ? b_ack : a_ack) === 1'b1) begin
                lat = c;
                err = p ? b_err : a_err;
                rd  = p ? b_rdata : a_rdata;
                break;
            end
        end
        drive_port(p, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic test_reset;
        logic [38:0] snap;
        reset = 1'b0; ram_clear = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) @(negedge clk);
        snap = {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, busy, MemWrite, MemRead, Address, WriteData};
        checks++;
        if (snap !== 39'd0) begin failures++; $display("FAIL reset_outputs got %h expected 0", snap); end
        reset = 1'b1; ram_clear = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 8'd7, 8'h77);
        @(negedge clk);
        checks++;
        if ({busy, MemWrite, Address} !== {1'b1, 1'b1, 8'd7}) begin
            failures++; $display("FAIL abort_setup got %b expected 1_1_00000111", {busy, MemWrite, Address});
        end
        reset = 1'b0;
        #1;
        checks++;
        if (MemWrite !== 1'b0) begin failures++; $display("FAIL abort_memwrite got %b expected 0", MemWrite); end
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (a_ack !== 1'b0) begin failures++; $display("FAIL abort_ack got %b expected 0", a_ack); end
        end
        snap = {a_ack, a_err, a_rdata, b_ack, b_err, b_rdata, busy, MemWrite, MemRead, Address, WriteData};
        checks++;
        if (snap !== 39'd0) begin failures++; $display("FAIL abort_outputs got %h expected 0", snap); end
        checks++;
        if (ram[7] !== 8'h00) begin failures++; $display("FAIL abort_ram got %h expected 00", ram[7]); end
        reset = 1'b1;
    endtask

    task automatic test_contention;
        int          ack_cyc[$];
        bit          ack_port[$];
        logic        e_err;
        logic [7:0]  e_rd;
        @(negedge clk);
        drive_port(1'b0, 1'b1, 1'b1, 8'd10, 8'hA1);
        drive_port(1'b1, 1'b1, 1'b1, 8'd11, 8'hB1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (a_ack === 1'b1) begin ack_cyc.push_back(c); ack_port.push_back(1'b0); end
            if (b_ack === 1'b1) begin ack_cyc.push_back(c); ack_port.push_back(1'b1); end
            if (ack_cyc.size() >= 4) break;
        end
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        checks++;
        if (ack_cyc.size() != 4) begin
            failures++; $display("FAIL contention_ack_count got %0d expected 4", ack_cyc.size());
        end
        for (int k = 0; k < ack_cyc.size() && k < 4; k++) begin
            checks++;
            if (ack_cyc[k] != 2 + 3 * k || ack_port[k] != bit'(k % 2)) begin
                failures++;
                $display("FAIL contention_order ack%0d got port=%0d cycle=%0d expected port=%0d cycle=%0d",
                         k, ack_port[k], ack_cyc[k], k % 2, 2 + 3 * k);
            end
            if (ack_port[k]) model_apply(1'b1, 1'b1, 8'd11, 8'hB1, e_err, e_rd);
            else             model_apply(1'b0, 1'b1, 8'd10, 8'hA1, e_err, e_rd);
        end
    endtask

    task automatic test_single;
        int lat; logic err; logic [7:0] rd; logic e_err; logic [7:0] e_rd;
        run_txn(1'b0, 1'b1, 8'd5, 8'hA5, lat, err, rd);
        model_apply(1'b0, 1'b1, 8'd5, 8'hA5, e_err, e_rd);
        checks++;
        if (lat != 2 || err !== 1'b0) begin
            failures++; $display("FAIL single_write got lat=%0d err=%b expected lat=2 err=0", lat, err);
        end
        @(negedge clk);
        checks++;
        if (a_ack !== 1'b0) begin failures++; $display("FAIL ack_pulse_width got %b expected 0", a_ack); end
        run_txn(1'b0, 1'b0, 8'd5, 8'h00, lat, err, rd);
        model_apply(1'b0, 1'b0, 8'd5, 8'h00, e_err, e_rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || rd !== 8'hA5) begin
            failures++; $display("FAIL single_read got lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=a5", lat, err, rd);
        end
    endtask

    task automatic test_out_of_range;
        int lat; int b0; logic err; logic [7:0] rd; logic e_err; logic [7:0] e_rd;
        b0 = bad_strobes;
        run_txn(1'b1, 1'b1, 8'd33, 8'hFF, lat, err, rd);
        model_apply(1'b1, 1'b1, 8'd33, 8'hFF, e_err, e_rd);
        checks++;
        if (lat != 2 || err !== 1'b1) begin
            failures++; $display("FAIL oor_write got lat=%0d err=%b expected lat=2 err=1", lat, err);
        end
        run_txn(1'b0, 1'b0, 8'd33, 8'h00, lat, err, rd);
        model_apply(1'b0, 1'b0, 8'd33, 8'h00, e_err, e_rd);
        checks++;
        if (err !== e_err || rd !== e_rd) begin
            failures++; $display("FAIL oor_read got err=%b rdata=%h expected err=%b rdata=%h", err, rd, e_err, e_rd);
        end
        checks++;
        if (bad_strobes != b0) begin
            failures++; $display("FAIL oor_strobe got %0d expected %0d", bad_strobes, b0);
        end
    endtask

    task automatic test_boundary;
        int lat; logic err; logic [7:0] rd; logic e_err; logic [7:0] e_rd;
        run_txn(1'b0, 1'b1, 8'd32, 8'h3C, lat, err, rd);
        model_apply(1'b0, 1'b1, 8'd32, 8'h3C, e_err, e_rd);
        run_txn(1'b0, 1'b0, 8'd32, 8'h00, lat, err, rd);
        model_apply(1'b0, 1'b0, 8'd32, 8'h00, e_err, e_rd);
        checks++;
        if (err !== 1'b0 || rd !== 8'h3C) begin
            failures++; $display("FAIL boundary_read got err=%b rdata=%h expected err=0 rdata=3c", err, rd);
        end
    endtask

    task automatic test_cross_port;
        int lat; logic err; logic [7:0] rd; logic e_err; logic [7:0] e_rd;
        run_txn(1'b0, 1'b1, 8'd0, 8'h11, lat, err, rd);
        model_apply(1'b0, 1'b1, 8'd0, 8'h11, e_err, e_rd);
        run_txn(1'b1, 1'b0, 8'd0, 8'h00, lat, err, rd);
        model_apply(1'b1, 1'b0, 8'd0, 8'h00, e_err, e_rd);
        checks++;
        if (lat != 2 || err !== 1'b0 || rd !== 8'h11) begin
            failures++; $display("FAIL cross_port_read got lat=%0d err=%b rdata=%h expected lat=2 err=0 rdata=11", lat, err, rd);
        end
    endtask

    task automatic test_random;
        bit         pend [2];
        int         waitc[2];
        bit         twe  [2];
        logic [7:0] tad  [2];
        logic [7:0] twd  [2];
        logic       ack, o_err, e_err;
        logic [7:0] o_rd, e_rd;
        for (int p = 0; p < 2; p++) begin pend[p] = 1'b0; waitc[p] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                ack   = (p == 0) ? a_ack   : b_ack;
                o_err = (p == 0) ? a_err   : b_err;
                o_rd  = (p == 0) ? a_rdata : b_rdata;
                if (ack === 1'b1) begin
                    checks++;
                    if (!pend[p]) begin
                        failures++; $display("FAIL rand_spurious_ack port=%0d got ack=1 expected 0", p);
                    end else begin
                        model_apply(p[0], twe[p], tad[p], twd[p], e_err, e_rd);
                        checks++;
                        if (o_err !== e_err || o_rd !== e_rd) begin
                            failures++;
                            $display("FAIL rand_resp port=%0d addr=%0d we=%0d got err=%b rdata=%h expected err=%b rdata=%h",
                                     p, tad[p], twe[p], o_err, o_rd, e_err, e_rd);
                        end
                        pend[p] = 1'b0;
                        drive_port(p[0], 1'b0, 1'b0, 8'h00, 8'h00);
                    end
                end else if (pend[p]) begin
                    waitc[p]++;
                    if (waitc[p] > 9) begin
                        checks++; failures++;
                        $display("FAIL rand_timeout port=%0d got no ack expected ack within 9 cycles", p);
                        pend[p] = 1'b0;
                        drive_port(p[0], 1'b0, 1'b0, 8'h00, 8'h00);
                    end
                end else if (cyc < 380 && $urandom_range(0, 2) != 0) begin
                    twe[p]   = 1'($urandom_range(0, 1));
                    tad[p]   = 8'($urandom_range(0, 36));
                    twd[p]   = 8'($urandom);
                    pend[p]  = 1'b1;
                    waitc[p] = 0;
                    drive_port(p[0], 1'b1, twe[p], tad[p], twd[p]);
                end
            end
        end
        checks++;
        if (pend[0] || pend[1]) begin
            failures++; $display("FAIL rand_drain got pending=%b%b expected 00", pend[0], pend[1]);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_out_of_range();
        test_boundary();
        test_cross_port();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
